// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer sharing one memory port and one ALU.
// Steps FETCH/DECODE/EXEC/MEM/WB, stops on HALT or unknown opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t           r_state;
  logic [6:0]       r_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_reg_write;
  logic [1:0] w_wb_sel;
  logic       w_alu_src;
  logic [1:0] w_alu_op;
  logic       w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (Opcode)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR,
      OP_LUI, OP_JAL, OP_JALR: w_legal = 1'b1;
      default:                 w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_iord      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 2'b00;
    w_reg_write = 1'b0;
    w_wb_sel    = 2'b00;
    w_alu_src   = 1'b0;
    w_alu_op    = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
      end
      S_EXEC: begin
        case (r_op)
          OP_R: w_alu_op = 2'b10;
          OP_I: begin
            w_alu_src = 1'b1;
            w_alu_op  = 2'b10;
          end
          OP_LW, OP_SW, OP_JALR: w_alu_src = 1'b1;
          OP_BR: begin
            w_alu_op   = 2'b01;
            w_pc_write = 1'b1;
            w_pc_src   = {1'b0, branch_taken};
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_mem_we   = (r_op == OP_SW);
        w_pc_write = (r_op == OP_SW) && mem_ready;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        case (r_op)
          OP_LW:           w_wb_sel = 2'b01;
          OP_JAL, OP_JALR: w_wb_sel = 2'b10;
          OP_LUI:          w_wb_sel = 2'b11;
          default:         w_wb_sel = 2'b00;
        endcase
        case (r_op)
          OP_JAL:  w_pc_src = 2'b01;
          OP_JALR: w_pc_src = 2'b10;
          default: w_pc_src = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  // pc_write marks retirement: it fires exactly once per completed instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_op      <= 7'd0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_pc_write) r_count <= r_count + CNT_W'(1);
      unique case (r_state)
        S_FETCH:
          if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_op <= Opcode;
          if (Opcode == OP_HALT) begin
            r_state <= S_HALTED;
          end else if (!w_legal) begin
            r_state   <= S_HALTED;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_BR:        r_state <= S_FETCH;
            OP_LW, OP_SW: r_state <= S_MEM;
            default:      r_state <= S_WB;
          endcase
        end
        S_MEM:
          if (mem_ready)
            r_state <= (r_op == OP_SW) ? S_FETCH : S_WB;
        S_WB:     r_state <= S_FETCH;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req     = w_mem_req & ~reset;
  assign mem_we      = w_mem_we & ~reset;
  assign iord        = w_iord & ~reset;
  assign ir_write    = w_ir_write & ~reset;
  assign pc_write    = w_pc_write & ~reset;
  assign pc_src      = reset ? 2'b00 : w_pc_src;
  assign reg_write   = w_reg_write & ~reset;
  assign wb_sel      = reset ? 2'b00 : w_wb_sel;
  assign alu_src     = w_alu_src & ~reset;
  assign alu_op      = reset ? 2'b00 : w_alu_op;
  assign halted      = (r_state == S_HALTED) & ~reset;
  assign illegal     = r_illegal & ~reset;
  assign instr_count = reset ? '0 : r_count;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I datapath, for builds where one unified memory port and one ALU are shared across phases.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath enables, muxes and the memory request handshake.
- Stops on the custom HALT opcode (7'b1111111) and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Opcode  in  7  opcode field from instruction register (valid from DECODE onward)
branch_taken  in  1  branch comparator result for current instruction
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe (valid with mem_req)
iord  out  1  memory address select: 0 PC, 1 ALU result
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR)
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate (LUI)
alu_src  out  1  0 rs2, 1 immediate
alu_op  out  2  00 add (LW/SW/JALR), 01 branch compare, 10 R/I-type funct decode
halted  out  1  sticky, core stopped
illegal  out  1  sticky, stopped on unknown opcode
instr_count  out  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Outputs are Moore/decoded from state plus the latched opcode `op_q`. Every output not listed for a state is 0.
- Reset: on any clk edge with reset=1, state=FETCH, op_q=0, halted=0, illegal=0, instr_count=0.
- While reset=1, all outputs are forced to 0, including mem_req.
- Reset mid-operation (any state, including MEM with mem_req high) aborts the instruction with no further pc_write or reg_write.
- FETCH: mem_req=1, iord=0.
  - mem_ready=0: hold.
  - mem_ready=1: ir_write=1 in the same cycle, go to DECODE.
- DECODE: op_q <= Opcode.
  - HALT goes to HALTED.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111, 1100111, 1111111} goes to HALTED and sets illegal=1.
  - Otherwise go to EXEC.
- EXEC (decoded from op_q):
  - R-type: alu_src=0, alu_op=10, go to WB.
  - I-imm: alu_src=1, alu_op=10, go to WB.
  - LW/SW: alu_src=1, alu_op=00, go to MEM.
  - JALR: alu_src=1, alu_op=00, go to WB.
  - JAL, LUI: go to WB, no ALU use.
  - BR: alu_op=01, pc_write=1, pc_src = branch_taken ? 01 : 00. This retires the instruction; go to FETCH.
- MEM: mem_req=1, iord=1, mem_we=(op_q==SW).
  - Hold until mem_ready=1.
  - LW: go to WB.
  - SW: pc_write=1, pc_src=00 in the mem_ready cycle; retire; go to FETCH.
- WB: reg_write=1, pc_write=1; retire; go to FETCH.
  - wb_sel: LW 01, JAL/JALR 10, LUI 11, else 00.
  - pc_src: JAL 01, JALR 10, else 00.
- HALTED: all strobes 0, halted=1. Leave only via reset.
- PC is written only at retirement, so PC+4 and PC+imm always refer to the current instruction.
- Retirement increments instr_count by 1, wrapping modulo 2^CNT_W. HALT and illegal opcodes do not count.
- Latency with mem_ready always 1:
  - BR: 3 cycles.
  - R/I/LUI/JAL/JALR: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Opcode changes after DECODE are ignored because op_q is used.
- mem_ready outside FETCH/MEM is ignored.
- At most one of ir_write/reg_write/mem_we is high per cycle.
- pc_write is high at most once per instruction.

Test Plan:
- `add` (0110011), mem_ready=1: FETCH→DECODE→EXEC→WB in 4 cycles. In WB: reg_write=1, wb_sel=00, pc_write=1, pc_src=00. instr_count 0→1.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM: 10 cycles total. mem_req/iord held stable during the waits. WB has wb_sel=01. mem_we=0 throughout.
- BEQ twice (branch_taken=1, then 0): 3 cycles each. EXEC shows pc_src=01 then 00. reg_write is never asserted. instr_count=2.
- JAL then JALR: WB shows wb_sel=10 with pc_src=01, then pc_src=10. SW: mem_we=1 only in MEM, retires without reg_write.
- HALT (1111111) after 3 instructions: halted=1 and instr_count stays at 3 for 20 cycles with no strobes. Opcode 0000000: halted=1, illegal=1.
- Assert reset in MEM of an SW with mem_req=1: next cycle state=FETCH, all outputs 0 while reset is held, instr_count=0, no pc_write; normal fetch resumes after reset drops.
